axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Byte-stream command bridge acting as the AXI-Lite initiator.
- Parses command frames from an 8-bit AXI-Stream (typically fed by a UART RX FIFO) and issues single AXI-Lite write/read transactions.
- Returns status and read data as an 8-bit AXI-Stream response.
- Drives one s_axil master port of the crossbar, giving host access to all peripheral register maps.

Parameters:
- AXIL_ADDR_WIDTH, 32, address width; multiple of 8; ADDR_BYTES = AXIL_ADDR_WIDTH/8.
- AXIL_DATA_WIDTH, 32, data width; multiple of 8; DATA_BYTES = AXIL_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one frame before abort; 0 disables.

Ports:
- clk_i  input  1  single clock for all logic.
- arstn_i  input  1  asynchronous active-low reset.
- s_axis  axis_if.slave  8-bit tdata  command byte stream (tdata/tvalid/tready used).
- m_axis  axis_if.master  8-bit tdata  response byte stream (tdata/tvalid/tready/tlast).
- m_axil  axil_if.master  AXIL_ADDR_WIDTH/AXIL_DATA_WIDTH  AXI-Lite initiator port.

Behaviour:
- Frame format, all multi-byte fields MSB first:
  - write = 0x01, ADDR_BYTES address bytes, DATA_BYTES data bytes.
  - read = 0x02, ADDR_BYTES address bytes.
- Responses:
  - write: 1 byte {6'b0, bresp}.
  - read: {6'b0, rresp}, then DATA_BYTES rdata bytes MSB first.
  - unknown opcode: 1 byte 0xFF.
  - tlast is asserted on the final byte of every response.
- Reset values: s_axis.tready=0, m_axis.tvalid=0, tlast=0, tdata=0; all m_axil valid/ready=0; addr/data regs=0; state=IDLE.
- States: IDLE, ADDR, DATA, WR, WR_RESP, RD, RD_RESP, RESP.
  - IDLE: tready=1. 0x01 or 0x02 -> ADDR with byte counter cleared; any other byte -> RESP with 0xFF.
  - ADDR: shift address in on each accepted byte. After ADDR_BYTES: write -> DATA, read -> RD.
  - DATA: shift data in. After DATA_BYTES -> WR.
  - WR: assert awvalid and wvalid together. Each is deasserted independently on its own handshake. wstrb = all ones; awprot = 3'b000. When both handshakes are done -> WR_RESP.
  - WR_RESP: bready=1. On bvalid, latch bresp -> RESP with length 1.
  - RD: arvalid held until arready -> RD_RESP.
  - RD_RESP: rready=1. On rvalid, latch rresp/rdata -> RESP with length 1+DATA_BYTES.
  - RESP: drive bytes in order; advance only on tvalid&tready; tvalid stays high and tdata stable under backpressure. After the last byte -> IDLE.
- s_axis.tready=1 only in IDLE/ADDR/DATA; 0 in all other states, so no command byte is lost or reordered.
- Latency: awvalid/wvalid (or arvalid) assert the cycle after the last frame byte is accepted. First response byte is valid the cycle after the bvalid/rvalid handshake.
- Ready/valid on the same cycle as valid assertion counts as an immediate handshake. A valid is never dropped before its handshake.
- Timeout:
  - Counter runs in ADDR/DATA only; clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES -> IDLE with no response and the partial frame discarded.
  - No timeout on AXI-Lite channels or on m_axis.
- Non-zero bresp/rresp is reported, not retried; in the read case the rdata bytes are still sent.
- Reset mid-operation returns to IDLE immediately. Any outstanding AXI-Lite transaction is abandoned; the interconnect is reset by the same arstn_i.

Decomposition:
- Shared package axil_cmd_pkg holds:
  - state enum;
  - opcode constants CMD_WRITE=8'h01, CMD_READ=8'h02, RSP_BAD_OPCODE=8'hFF;
  - resp status byte layout.
- One natural sub-module: axil_cmd_timeout, a loadable counter with a clear and expiry pulse.
- Everything else stays in one FSM module.

Test Plan:
- Write path: send 01 00 00 00 10 DE AD BE EF, slaves ready immediately -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF; bresp=0 -> response 0x00 with tlast.
- Read path: send 02 00 00 00 20; slave returns rdata=0x12345678, rresp=0 -> araddr=0x20; response 00 12 34 56 78, tlast on 0x78 only.
- Split handshake: awready delayed 3 cycles, wready immediate -> wvalid low after 1 cycle, awvalid held 4 cycles; single bready handshake; response 0x00.
- Error and backpressure: send bad opcode 0x7E -> response 0xFF. Read returns rresp=2 while m_axis.tready is toggled -> 02 then data bytes, each held stable until accepted.
- Timeout: TIMEOUT_CYCLES=16; send 01 00 00, then wait 20 cycles -> no AXI-Lite activity and no response; next frame 02 00 00 00 04 executes normally.
- Reset: assert arstn_i during WR with awvalid high -> all outputs return to reset values asynchronously; after release a new read frame completes correctly.

Source files
------------

// File: rtl/axil_cmd_pkg.sv
// Shared definitions for the byte-stream to AXI-Lite command bridge.
// Holds the FSM state encoding, the command/response opcode bytes and
// the layout of the one-byte status that leads every response.
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_RESP,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE      = 8'h01;
    localparam logic [7:0] CMD_READ       = 8'h02;
    localparam logic [7:0] RSP_BAD_OPCODE = 8'hFF;

    // Status byte: upper six bits zero, AXI response code in the low two.
    typedef struct packed {
        logic [5:0] pad;
        logic [1:0] resp;
    } status_t;

    function automatic logic [7:0] status_byte(input logic [1:0] resp);
        status_t s;
        s.pad  = '0;
        s.resp = resp;
        return s;
    endfunction

endpackage

// File: rtl/axil_cmd_timeout.sv
// Inter-byte timeout counter for partially received command frames.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   run         - count while high (frame reception in progress)
//   clear       - restart the count (a frame byte was accepted)
//   expired     - single-cycle pulse when TIMEOUT_CYCLES idle cycles elapsed
// TIMEOUT_CYCLES = 0 disables the timeout entirely.
module axil_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle cycle, so the
    // owner leaves its receive state exactly that many cycles after the last byte.
    assign expired = (TIMEOUT_CYCLES != 0) && run && !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !run || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axil_cmd_master.sv
// Byte-stream command bridge acting as an AXI-Lite initiator.
// Command frames (MSB-first fields) arrive on s_axis:
//   0x01 addr[ADDR_BYTES] data[DATA_BYTES]  -> single write, reply {6'b0,bresp}
//   0x02 addr[ADDR_BYTES]                   -> single read,  reply {6'b0,rresp} rdata[DATA_BYTES]
//   anything else                           -> reply 0xFF
// Ports:
//   clk_i, arstn_i      - clock and asynchronous active-low reset
//   s_axis_*            - 8-bit command stream in (tdata/tvalid/tready)
//   m_axis_*            - 8-bit response stream out, tlast on final byte
//   m_axil_*            - AXI-Lite initiator port
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int          AXIL_ADDR_WIDTH = 32,
    parameter int          AXIL_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic [7:0]                   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]                   m_axil_awprot,
    output logic                         m_axil_awvalid,
    input  logic                         m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                         m_axil_wvalid,
    input  logic                         m_axil_wready,
    input  logic [1:0]                   m_axil_bresp,
    input  logic                         m_axil_bvalid,
    output logic                         m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]                   m_axil_arprot,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready
);

    localparam int         ADDR_BYTES = AXIL_ADDR_WIDTH / 8;
    localparam int         DATA_BYTES = AXIL_DATA_WIDTH / 8;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_BYTES - 1);
    localparam logic [7:0] DATA_CNT   = 8'(DATA_BYTES);

    state_t                       state;
    logic                         is_write;
    logic [7:0]                   byte_cnt;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_reg;
    logic [AXIL_DATA_WIDTH-1:0]   data_reg;
    logic [AXIL_DATA_WIDTH-1:0]   rsp_shift;
    logic [7:0]                   rsp_left;
    logic                         accept;
    logic                         expired;

    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_axil_awaddr = addr_reg;
    assign m_axil_araddr = addr_reg;
    assign m_axil_wdata  = data_reg;
    assign m_axil_wstrb  = '1;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    axil_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (arstn_i),
        .run    ((state == ST_ADDR) || (state == ST_DATA)),
        .clear  (accept),
        .expired(expired)
    );

    // Frame parser and transaction sequencer. s_axis_tready is registered and
    // set together with every transition so it is high only in IDLE/ADDR/DATA.
    // The response is preloaded into m_axis_tdata with the remaining bytes
    // queued MSB-first in rsp_shift; rsp_left counts bytes still to follow.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state          <= ST_IDLE;
            is_write       <= 1'b0;
            byte_cnt       <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            rsp_shift      <= '0;
            rsp_left       <= '0;
            s_axis_tready  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_axis_tready <= 1'b1;
                    if (accept) begin
                        byte_cnt <= '0;
                        if (s_axis_tdata == CMD_WRITE || s_axis_tdata == CMD_READ) begin
                            is_write <= (s_axis_tdata == CMD_WRITE);
                            state    <= ST_ADDR;
                        end else begin
                            s_axis_tready <= 1'b0;
                            m_axis_tdata  <= RSP_BAD_OPCODE;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            rsp_left      <= '0;
                            state         <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        addr_reg <= (addr_reg << 8) | AXIL_ADDR_WIDTH'(s_axis_tdata);
                        byte_cnt <= byte_cnt + 8'd1;
                        if (byte_cnt == ADDR_LAST) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                s_axis_tready  <= 1'b0;
                                m_axil_arvalid <= 1'b1;
                                state          <= ST_RD;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        data_reg <= (data_reg << 8) | AXIL_DATA_WIDTH'(s_axis_tdata);
                        byte_cnt <= byte_cnt + 8'd1;
                        if (byte_cnt == DATA_LAST) begin
                            byte_cnt       <= '0;
                            s_axis_tready  <= 1'b0;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    // Both channels are finished once each is either already
                    // done or completing its handshake in this cycle.
                    if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
                        m_axil_bready <= 1'b1;
                        state         <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        m_axis_tdata  <= status_byte(m_axil_bresp);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        rsp_left      <= '0;
                        state         <= ST_RESP;
                    end
                end
                ST_RD: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        m_axis_tdata  <= status_byte(m_axil_rresp);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        rsp_shift     <= m_axil_rdata;
                        rsp_left      <= DATA_CNT;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axis_tready) begin
                        if (rsp_left == 8'd0) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            s_axis_tready <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            m_axis_tdata <= rsp_shift[AXIL_DATA_WIDTH-1 -: 8];
                            rsp_shift    <= rsp_shift << 8;
                            rsp_left     <= rsp_left - 8'd1;
                            m_axis_tlast <= (rsp_left == 8'd1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: a table of command frames with
// hand-computed AXI-Lite and response expectations, plus hand-written
// timeout and mid-transaction reset sequences.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave behaviour knobs, set by the stimulus process.
    int          aw_dly = 0, w_dly = 0;
    logic [1:0]  resp_val = 2'b00;
    logic [31:0] rdata_val = 32'h0;
    bit          toggle_en = 1'b0;

    int   aw_wait, w_wait;
    logic aw_done, w_done;
    logic tgl = 1'b0;

    // Observation counters and captured transaction fields.
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_hi = 0, w_hi = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;
    logic [8:0]  rsp_mem [0:255];
    int          rsp_wr = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_beat = 9'h0;

    typedef struct {
        logic [71:0] frame;
        int          flen;
        int          kind;
        int          adly;
        int          wdly;
        logic [1:0]  resp;
        logic [31:0] rd;
        bit          tog;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_aw_hi;
        int          exp_w_hi;
        logic [39:0] rsp;
        int          rlen;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    assign awready  = (aw_wait >= aw_dly);
    assign wready   = (w_wait >= w_dly);
    assign arready  = 1'b1;
    assign m_tready = toggle_en ? tgl : 1'b1;

    axil_cmd_master #(
        .AXIL_ADDR_WIDTH(32),
        .AXIL_DATA_WIDTH(32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .m_axil_awaddr (awaddr),
        .m_axil_awprot (awprot),
        .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata  (wdata),
        .m_axil_wstrb  (wstrb),
        .m_axil_wvalid (wvalid),
        .m_axil_wready (wready),
        .m_axil_bresp  (bresp),
        .m_axil_bvalid (bvalid),
        .m_axil_bready (bready),
        .m_axil_araddr (araddr),
        .m_axil_arprot (arprot),
        .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata  (rdata),
        .m_axil_rresp  (rresp),
        .m_axil_rvalid (rvalid),
        .m_axil_rready (rready)
    );

    // AXI-Lite slave model: ready on the address/write channels after a
    // programmable number of valid cycles, write response once both land,
    // read data the cycle after the address handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0;
            w_wait  <= 0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= 32'h0;
        end else begin
            if (awvalid && awready) begin
                aw_wait <= 0;
                aw_done <= 1'b1;
            end else if (awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (wvalid && wready) begin
                w_wait <= 0;
                w_done <= 1'b1;
            end else if (wvalid) begin
                w_wait <= w_wait + 1;
            end
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (aw_done && w_done && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= resp_val;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rdata_val;
                rresp  <= resp_val;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Handshake counters, valid-high cycle counters and field capture.
    always @(posedge clk) begin
        if (awvalid) aw_hi <= aw_hi + 1;
        if (wvalid)  w_hi  <= w_hi + 1;
        if (awvalid && awready) begin
            aw_hs      <= aw_hs + 1;
            cap_awaddr <= awaddr;
        end
        if (wvalid && wready) begin
            w_hs      <= w_hs + 1;
            cap_wdata <= wdata;
            cap_wstrb <= wstrb;
        end
        if (bvalid && bready) b_hs <= b_hs + 1;
        if (arvalid && arready) begin
            ar_hs      <= ar_hs + 1;
            cap_araddr <= araddr;
        end
        if (rvalid && rready) r_hs <= r_hs + 1;
    end

    // Response sink: records accepted beats and flags any beat that changed
    // or vanished while it was being held off by backpressure.
    always @(posedge clk) begin
        tgl <= ~tgl;
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                rsp_mem[rsp_wr[7:0]] <= {m_tlast, m_tdata};
                rsp_wr <= rsp_wr + 1;
            end
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} != prev_beat))
                stab_err <= stab_err + 1;
            prev_stall <= m_tvalid && !m_tready;
            prev_beat  <= {m_tlast, m_tdata};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offers one byte starting at a negative edge; returns at the negative
    // edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!s_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL send_byte: tready stayed 0 for byte %0h, expected 1", b);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [71:0] frame, input int flen);
        for (int i = 0; i < flen; i++) send_byte(frame[71-8*i -: 8]);
    endtask

    task automatic wait_and_check_rsp(input string tag, input int base, input logic [39:0] exp, input int len);
        int n = 0;
        while ((rsp_wr - base) < len && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput({tag, ".rsp_count"}, 64'(rsp_wr - base), 64'(len));
        for (int i = 0; i < len; i++) begin
            logic [8:0] beat;
            beat = rsp_mem[(base + i) % 256];
            checkOutput($sformatf("%s.rsp[%0d].data", tag, i), 64'(beat[7:0]), 64'(exp[39-8*i -: 8]));
            checkOutput($sformatf("%s.rsp[%0d].last", tag, i), 64'(beat[8]), 64'(i == len - 1));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b_aw, b_w, b_b, b_ar, b_r, b_awh, b_wh, b_rsp;

        vecs[0] = '{frame: 72'h01_00000010_DEADBEEF, flen: 9, kind: 0, adly: 0, wdly: 0, resp: 2'd0,
                    rd: 32'h0, tog: 1'b0, exp_addr: 32'h10, exp_wdata: 32'hDEADBEEF,
                    exp_aw_hi: 1, exp_w_hi: 1, rsp: 40'h00_00000000, rlen: 1};
        vecs[1] = '{frame: 72'h02_00000020_00000000, flen: 5, kind: 1, adly: 0, wdly: 0, resp: 2'd0,
                    rd: 32'h12345678, tog: 1'b0, exp_addr: 32'h20, exp_wdata: 32'h0,
                    exp_aw_hi: 0, exp_w_hi: 0, rsp: 40'h00_12345678, rlen: 5};
        vecs[2] = '{frame: 72'h01_00000040_00000055, flen: 9, kind: 0, adly: 3, wdly: 0, resp: 2'd0,
                    rd: 32'h0, tog: 1'b0, exp_addr: 32'h40, exp_wdata: 32'h55,
                    exp_aw_hi: 4, exp_w_hi: 1, rsp: 40'h00_00000000, rlen: 1};
        vecs[3] = '{frame: 72'h7E_00000000_00000000, flen: 1, kind: 2, adly: 0, wdly: 0, resp: 2'd0,
                    rd: 32'h0, tog: 1'b0, exp_addr: 32'h0, exp_wdata: 32'h0,
                    exp_aw_hi: 0, exp_w_hi: 0, rsp: 40'hFF_00000000, rlen: 1};
        vecs[4] = '{frame: 72'h02_ABCD0008_00000000, flen: 5, kind: 1, adly: 0, wdly: 0, resp: 2'd2,
                    rd: 32'hCAFEF00D, tog: 1'b1, exp_addr: 32'hABCD0008, exp_wdata: 32'h0,
                    exp_aw_hi: 0, exp_w_hi: 0, rsp: 40'h02_CAFEF00D, rlen: 5};
        vecs[5] = '{frame: 72'h01_12345678_00000001, flen: 9, kind: 0, adly: 0, wdly: 2, resp: 2'd3,
                    rd: 32'h0, tog: 1'b0, exp_addr: 32'h12345678, exp_wdata: 32'h00000001,
                    exp_aw_hi: 1, exp_w_hi: 3, rsp: 40'h03_00000000, rlen: 1};

        // Asynchronous reset values before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset.outputs",
                    64'({s_tready, m_tvalid, m_tlast, awvalid, wvalid, bready, arvalid, rready}), 64'h0);
        checkOutput("reset.tdata", 64'(m_tdata), 64'h0);
        checkOutput("reset.addr_data", {awaddr, wdata}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag       = $sformatf("vec%0d", v);
            aw_dly    = vecs[v].adly;
            w_dly     = vecs[v].wdly;
            resp_val  = vecs[v].resp;
            rdata_val = vecs[v].rd;
            toggle_en = vecs[v].tog;
            b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs;
            b_awh = aw_hi; b_wh = w_hi; b_rsp = rsp_wr;

            applyStimulus(vecs[v].frame, vecs[v].flen);
            if (vecs[v].kind == 0)
                checkOutput({tag, ".aw_w_latency"}, 64'({awvalid, wvalid}), 64'b11);
            else if (vecs[v].kind == 1)
                checkOutput({tag, ".ar_latency"}, 64'(arvalid), 64'b1);

            wait_and_check_rsp(tag, b_rsp, vecs[v].rsp, vecs[v].rlen);

            checkOutput({tag, ".aw_hs"}, 64'(aw_hs - b_aw), 64'(vecs[v].kind == 0));
            checkOutput({tag, ".ar_hs"}, 64'(ar_hs - b_ar), 64'(vecs[v].kind == 1));
            if (vecs[v].kind == 0) begin
                checkOutput({tag, ".w_hs"}, 64'(w_hs - b_w), 64'd1);
                checkOutput({tag, ".b_hs"}, 64'(b_hs - b_b), 64'd1);
                checkOutput({tag, ".awaddr"}, 64'(cap_awaddr), 64'(vecs[v].exp_addr));
                checkOutput({tag, ".wdata"}, 64'(cap_wdata), 64'(vecs[v].exp_wdata));
                checkOutput({tag, ".wstrb"}, 64'(cap_wstrb), 64'hF);
                checkOutput({tag, ".awvalid_cycles"}, 64'(aw_hi - b_awh), 64'(vecs[v].exp_aw_hi));
                checkOutput({tag, ".wvalid_cycles"}, 64'(w_hi - b_wh), 64'(vecs[v].exp_w_hi));
            end else if (vecs[v].kind == 1) begin
                checkOutput({tag, ".r_hs"}, 64'(r_hs - b_r), 64'd1);
                checkOutput({tag, ".araddr"}, 64'(cap_araddr), 64'(vecs[v].exp_addr));
            end
        end
        toggle_en = 1'b0;
        checkOutput("backpressure.stable", 64'(stab_err), 64'd0);

        // Timeout: a truncated write frame is dropped silently after 16 idle
        // cycles; the following read must be parsed from its opcode.
        b_aw = aw_hs; b_ar = ar_hs; b_awh = aw_hi; b_rsp = rsp_wr;
        resp_val  = 2'd0;
        rdata_val = 32'h000000A5;
        applyStimulus(72'h01_0000_0000_0000_0000, 3);
        repeat (20) @(negedge clk);
        checkOutput("timeout.no_rsp", 64'(rsp_wr - b_rsp), 64'd0);
        checkOutput("timeout.no_aw", 64'((aw_hs - b_aw) + (aw_hi - b_awh)), 64'd0);
        checkOutput("timeout.no_ar", 64'(ar_hs - b_ar), 64'd0);
        b_rsp = rsp_wr;
        applyStimulus(72'h02_00000004_00000000, 5);
        checkOutput("timeout.next_ar_latency", 64'(arvalid), 64'b1);
        wait_and_check_rsp("timeout.next", b_rsp, 40'h00_000000A5, 5);
        checkOutput("timeout.next_araddr", 64'(cap_araddr), 64'h4);
        checkOutput("timeout.next_ar_hs", 64'(ar_hs - b_ar), 64'd1);

        // Reset while a write address is stalled by the slave.
        aw_dly = 10;
        b_aw = aw_hs; b_rsp = rsp_wr;
        applyStimulus(72'h01_00000050_11223344, 9);
        @(negedge clk);
        checkOutput("rst_mid.awvalid_before", 64'(awvalid), 64'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.outputs",
                    64'({s_tready, m_tvalid, m_tlast, awvalid, wvalid, bready, arvalid, rready}), 64'h0);
        checkOutput("rst_mid.addr_data", {awaddr, wdata}, 64'h0);
        aw_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid.no_aw_hs", 64'(aw_hs - b_aw), 64'd0);
        b_ar = ar_hs;
        rdata_val = 32'h0BADF00D;
        applyStimulus(72'h02_00000030_00000000, 5);
        wait_and_check_rsp("rst_mid.read", b_rsp, 40'h00_0BADF00D, 5);
        checkOutput("rst_mid.araddr", 64'(cap_araddr), 64'h30);
        checkOutput("rst_mid.ar_hs", 64'(ar_hs - b_ar), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
